// File: rtl/rv32v_mul_issue_ctrl.sv
// Issue controller for the vector multiply unit: walks the elements of one
// instruction through operand fetch, multiply start/done and writeback.
module rv32v_mul_issue_ctrl #(
    parameter int MAX_VL  = 64,
    parameter int IDX_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [IDX_W-1:0] issue_vl,
    input  logic [1:0]       issue_sew,
    input  logic [1:0]       issue_signed,
    input  logic             issue_sign_type,
    input  logic [1:0]       issue_mtype,
    input  logic             issue_high,
    input  logic             issue_widen,
    input  logic             issue_posneg,
    input  logic [4:0]       issue_vd,
    input  logic             kill,
    output logic             op_req,
    output logic [IDX_W-1:0] op_idx,
    input  logic [31:0]      op_vs1,
    input  logic [31:0]      op_vs2,
    input  logic [31:0]      op_vs3,
    output logic             mu_start,
    output logic [31:0]      mu_vs1,
    output logic [31:0]      mu_vs2,
    output logic [31:0]      mu_vs3,
    output logic [1:0]       mu_sew,
    output logic [1:0]       mu_is_signed_mul,
    output logic             mu_is_signed,
    output logic [1:0]       mu_multiply_type,
    output logic             mu_high_low,
    output logic             mu_widen,
    output logic             mu_pos_neg,
    output logic             mu_decode_done,
    input  logic             mu_busy,
    input  logic             mu_done,
    input  logic [31:0]      mu_wdata,
    input  logic             mu_exception,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_vd,
    output logic [IDX_W-1:0] wb_idx,
    output logic [31:0]      wb_data,
    output logic             cmpl_valid,
    output logic             cmpl_exception,
    output logic [IDX_W-1:0] cmpl_count
);

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_step;
    state_t            w_next;
    logic [IDX_W-1:0]  r_elem;
    logic [IDX_W-1:0]  r_vl;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_exc;
    logic [IDX_W-1:0]  w_vl_eff;
    logic              w_last;
    logic              w_tmo_hit;

    logic              r_issue_ready;
    logic              r_op_req;
    logic              r_mu_start;
    logic              r_wb_valid;
    logic              r_decode_done;
    logic              r_cmpl_valid;
    logic              r_cmpl_exc;
    logic [IDX_W-1:0]  r_cmpl_count;
    logic [31:0]       r_mu_vs1;
    logic [31:0]       r_mu_vs2;
    logic [31:0]       r_mu_vs3;
    logic [1:0]        r_sew;
    logic [1:0]        r_signed;
    logic              r_sign_type;
    logic [1:0]        r_mtype;
    logic              r_high;
    logic              r_widen;
    logic              r_posneg;
    logic [4:0]        r_vd;
    logic [31:0]       r_wb_data;

    assign w_vl_eff  = (issue_vl > IDX_W'(MAX_VL)) ? IDX_W'(MAX_VL) : issue_vl;
    assign w_last    = ((r_elem + IDX_W'(1)) == r_vl);
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT));
    // kill overrides every transition except from IDLE, where it only blocks acceptance
    assign w_next    = (kill && (r_state != S_IDLE)) ? S_IDLE : w_step;

    // Next-state selection before kill is applied
    always_comb begin
        w_step = r_state;
        case (r_state)
            S_IDLE: begin
                if (issue_valid && !kill) begin
                    w_step = (w_vl_eff == {IDX_W{1'b0}}) ? S_DONE : S_FETCH;
                end else begin
                    w_step = S_IDLE;
                end
            end
            S_FETCH: begin
                if (!mu_busy) begin
                    w_step = S_START;
                end else begin
                    w_step = S_FETCH;
                end
            end
            S_START: w_step = S_WAIT;
            S_WAIT: begin
                if (mu_done) begin
                    w_step = mu_exception ? S_DONE : S_WB;
                end else if (w_tmo_hit) begin
                    w_step = S_DONE;
                end else begin
                    w_step = S_WAIT;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    w_step = w_last ? S_DONE : S_FETCH;
                end else begin
                    w_step = S_WB;
                end
            end
            S_DONE:  w_step = S_IDLE;
            default: w_step = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_elem        <= {IDX_W{1'b0}};
            r_vl          <= {IDX_W{1'b0}};
            r_tmo         <= {TMO_W{1'b0}};
            r_exc         <= 1'b0;
            r_issue_ready <= 1'b1;
            r_op_req      <= 1'b0;
            r_mu_start    <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_decode_done <= 1'b0;
            r_cmpl_valid  <= 1'b0;
            r_cmpl_exc    <= 1'b0;
            r_cmpl_count  <= {IDX_W{1'b0}};
            r_mu_vs1      <= 32'd0;
            r_mu_vs2      <= 32'd0;
            r_mu_vs3      <= 32'd0;
            r_sew         <= 2'd0;
            r_signed      <= 2'd0;
            r_sign_type   <= 1'b0;
            r_mtype       <= 2'd0;
            r_high        <= 1'b0;
            r_widen       <= 1'b0;
            r_posneg      <= 1'b0;
            r_vd          <= 5'd0;
            r_wb_data     <= 32'd0;
        end else begin
            r_state       <= w_next;
            r_issue_ready <= (w_next == S_IDLE);
            r_op_req      <= (w_next == S_FETCH);
            r_mu_start    <= (w_next == S_START);
            r_wb_valid    <= (w_next == S_WB);
            r_decode_done <= (w_next == S_FETCH) || (w_next == S_START) ||
                             (w_next == S_WAIT)  || (w_next == S_WB);
            // completion is reported as a registered pulse leaving DONE
            r_cmpl_valid  <= (r_state == S_DONE) && !kill;
            if (r_state == S_DONE) begin
                r_cmpl_count <= r_elem;
                r_cmpl_exc   <= r_exc;
            end else begin
                r_cmpl_count <= {IDX_W{1'b0}};
                r_cmpl_exc   <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (issue_valid && !kill) begin
                        r_vl        <= w_vl_eff;
                        r_elem      <= {IDX_W{1'b0}};
                        r_exc       <= 1'b0;
                        r_tmo       <= {TMO_W{1'b0}};
                        r_sew       <= issue_sew;
                        r_signed    <= issue_signed;
                        r_sign_type <= issue_sign_type;
                        r_mtype     <= issue_mtype;
                        r_high      <= issue_high;
                        r_widen     <= issue_widen;
                        r_posneg    <= issue_posneg;
                        r_vd        <= issue_vd;
                    end
                end
                S_FETCH: begin
                    if (!mu_busy && !kill) begin
                        r_mu_vs1 <= op_vs1;
                        r_mu_vs2 <= op_vs2;
                        r_mu_vs3 <= op_vs3;
                    end
                end
                S_START: r_tmo <= {TMO_W{1'b0}};
                S_WAIT: begin
                    if (!kill) begin
                        if (mu_done) begin
                            r_wb_data <= mu_wdata;
                            r_exc     <= mu_exception;
                        end else if (w_tmo_hit) begin
                            r_exc <= 1'b1;
                        end else begin
                            r_tmo <= r_tmo + TMO_W'(1);
                        end
                    end
                end
                S_WB: begin
                    if (wb_ready && !kill) begin
                        r_elem <= r_elem + IDX_W'(1);
                    end
                end
                S_DONE:  r_exc <= 1'b0;
                default: r_exc <= 1'b0;
            endcase
        end
    end

    assign issue_ready      = r_issue_ready;
    assign op_req           = r_op_req;
    assign op_idx           = r_elem;
    assign mu_start         = r_mu_start;
    assign mu_vs1           = r_mu_vs1;
    assign mu_vs2           = r_mu_vs2;
    assign mu_vs3           = r_mu_vs3;
    assign mu_sew           = r_sew;
    assign mu_is_signed_mul = r_signed;
    assign mu_is_signed     = r_sign_type;
    assign mu_multiply_type = r_mtype;
    assign mu_high_low      = r_high;
    assign mu_widen         = r_widen;
    assign mu_pos_neg       = r_posneg;
    assign mu_decode_done   = r_decode_done;
    assign wb_valid         = r_wb_valid;
    assign wb_vd            = r_vd;
    assign wb_idx           = r_elem;
    assign wb_data          = r_wb_data;
    assign cmpl_valid       = r_cmpl_valid;
    assign cmpl_exception   = r_cmpl_exc;
    assign cmpl_count       = r_cmpl_count;

endmodule
